addn_seq: RTL and testbench
===========================

// Module: addn_seq
// PURPOSE
//   Multi-cycle N-bit adder: processes one W-bit chunk per clock, LSB chunk first, using a
//   registered ripple carry. Adds carry-in, carry-out, signed overflow and a valid/ready handshake.
//   Successor to the combinational N-bit ripple adder; used where area matters more than latency.
// PARAMETERS
//   N  32  operand/result width; N % W != 0 is an elaboration error
//   W   8  chunk width added per cycle; W == N gives a single-cycle RUN
// PORTS
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high
//   in_valid   in   1  operands valid
//   in_ready   out  1  block accepts operands (IDLE only)
//   a          in   N  operand A
//   b          in   N  operand B
//   cin        in   1  carry-in
//   sub        in   1  1: A + ~B + cin (present only with ADDN_SEQ_SUB_EN)
//   out_valid  out  1  result valid, held until accepted
//   out_ready  in   1  consumer accepts result
//   sum        out  N  result
//   cout       out  1  carry out of bit N-1
//   overflow   out  1  two's-complement overflow
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, sum=0, cout=0, overflow=0, chunk index=0, carry reg=0.
//     in_ready = (state==IDLE) && !reset. Reset in any state aborts the operation; no result is produced.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     IDLE: when in_valid && in_ready: latch a, b' (b, or ~b if sub), carry=cin, idx=0 -> RUN.
//     RUN: each cycle sum[idx*W +: W] = a[idx] + b'[idx] + carry; carry <= chunk carry-out;
//          idx++. After chunk N/W-1 completes -> DONE.
//     DONE: out_valid=1; sum/cout/overflow stable; in_ready=0, in_valid ignored.
//          On out_valid && out_ready -> IDLE (out_valid drops next cycle; sum etc. keep their values).
//   - Latency: out_valid asserts exactly N/W cycles after the acceptance edge.
//     Throughput: at most one operation per N/W+2 cycles.
//   - cout = carry out of the final chunk. overflow = (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]).
//   - Subtract: cout=1 means no borrow. The caller drives cin=1 for a plain A-B.
//   - Operand inputs are sampled only on the acceptance edge; later changes have no effect.
// CONFIGURATION
//   ADDN_SEQ_SUB_EN defined: sub port exists; b' = sub ? ~b : b, latched at acceptance.
//   Undefined: no sub port; b' = b; block is add-only.
// STRUCTURE
//   - adder_pkg: FSM state encoding localparams (IDLE/RUN/DONE), chunk-count helper function.
//   - Sub-module addw (W-bit ripple chunk adder with carry-in/carry-out) built from the
//     existing 1-bit adder cell. One instance, reused every cycle.
//   - Index counter width: $clog2(N/W), minimum 1.
// TESTING
//   1. N=32,W=8: a=FFFFFFFF, b=1, cin=0 -> sum=0, cout=1, overflow=0; out_valid 4 cycles after acceptance.
//   2. a=7FFFFFFF, b=1, cin=0 -> sum=80000000, cout=0, overflow=1.
//   3. SUB_EN: a=5, b=7, sub=1, cin=1 -> sum=FFFFFFFE, cout=0 (borrow), overflow=0.
//   4. Hold out_ready=0 for 10 cycles in DONE, toggling in_valid/a -> sum stable, in_ready=0, no new accept.
//   5. Assert reset in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0; a new op completes correctly.
//   6. N=8,W=8: a=80, b=80, cin=0 -> sum=00, cout=1, overflow=1, latency 1 cycle.

Source files
------------

// File: rtl/addn_seq_pkg.sv
// Shared definitions for the sequential chunked adder: FSM encoding, sizing helpers
// and the 1-bit full-adder cell used to build the chunk adder.
package addn_seq_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic int unsigned num_chunks(int unsigned n, int unsigned w);
    return n / w;
  endfunction

  // Chunk index counter never narrower than one bit, even for a single chunk.
  function automatic int unsigned idx_width(int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  // 1-bit full adder cell, result packed as {carry, sum}.
  function automatic logic [1:0] full_add(logic x, logic y, logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/addn_seq_addw.sv
// W-bit ripple-carry chunk adder assembled from the 1-bit full-adder cell.
module addw
  import addn_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [1:0] res;
    assign res          = full_add(a[i], b[i], carry[i]);
    assign sum[i]       = res[0];
    assign carry[i + 1] = res[1];
  end

  assign cout = carry[W];

endmodule

// File: rtl/addn_seq.sv
// Multi-cycle N-bit adder: one W-bit chunk per clock, LSB first, with valid/ready handshake.
// Optional subtract support (sub port) is enabled by defining ADDN_SEQ_SUB_EN.
module addn_seq
  import addn_seq_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef ADDN_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned Chunks = num_chunks(N, W);
  localparam int unsigned IdxW   = idx_width(Chunks);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Chunks - 1);

  if ((W == 0) || (N % W != 0)) begin : g_bad_cfg
    $error("addn_seq: N must be a non-zero multiple of W");
  end

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [N-1:0] b_eff;
  logic [W-1:0] a_chunk, b_chunk, chunk_sum;
  logic         chunk_cout;
  logic         accept;

`ifdef ADDN_SEQ_SUB_EN
  assign b_eff = sub ? ~b : b;
`else
  assign b_eff = b;
`endif

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

  assign a_chunk = a_q[idx_q * W +: W];
  assign b_chunk = b_q[idx_q * W +: W];

  // Single chunk adder shared across all RUN cycles.
  addw #(
    .W (W)
  ) u_addw (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q * W +: W] = chunk_sum;
        carry_d = chunk_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = chunk_cout;
          // Final sum MSB comes straight from this chunk, not yet in sum_q.
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (chunk_sum[W-1] != a_q[N-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_addn_seq.sv
// Scoreboard bench for addn_seq: driver pushes expected results, a monitor pops and compares.
module tb_addn_seq;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
`ifdef ADDN_SEQ_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       out_valid8;
  logic [7:0] sum8;
  logic       cout8;
  logic       ovf8;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;  // 0 random, 1 held low, 2 held high
  bit   lat_seen = 0;

  addn_seq #(.N(32), .W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDN_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  addn_seq #(.N(8), .W(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (1'b0),
`ifdef ADDN_SEQ_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .sum       (sum8),
    .cout      (cout8),
    .overflow  (ovf8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic on the effective operands.
  function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic ci, logic s);
    exp_t        e;
    logic [31:0] yy;
    logic [32:0] full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + 33'(ci);
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (x[31] == yy[31]) && (full[31] != x[31]);
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic s);
    exp_t e;
    bit   done = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
`ifdef ADDN_SEQ_SUB_EN
    sub      = s;
`endif
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (in_ready) begin
        e = model(x, y, ci, s);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) check("unexpected_output", 64'd1, 64'd0);
      end else begin
        if (!lat_seen) begin
          check("latency", 64'(cyc), 64'(sb[0].acc_cyc + 4));
          lat_seen = 1;
        end
        if (out_ready) begin
          mon_e = sb.pop_front();
          check("sum", 64'(sum), 64'(mon_e.sum));
          check("cout", 64'(cout), 64'(mon_e.cout));
          check("overflow", 64'(overflow), 64'(mon_e.ovf));
          lat_seen = 0;
        end
      end
    end
  end

  initial begin
    logic s_r;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Wrap to zero, then signed overflow at the positive limit.
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();
`ifdef ADDN_SEQ_SUB_EN
    issue(32'h5, 32'h7, 1'b1, 1'b1);
    drain();
`endif

    // Result held in DONE while the consumer stalls.
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a        = $urandom;
      #1;
      check("hold_sum", 64'(sum), 64'h2345_6789);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    drain();
    repeat (2) @(negedge clk);
    check("hold_no_extra", 64'(out_valid), 64'd0);

    // Abort in the second RUN cycle.
    issue(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    void'(sb.pop_front());
    lat_seen = 0;
    @(negedge clk);
    issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    drain();

    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
`ifdef ADDN_SEQ_SUB_EN
      s_r = 1'($urandom_range(0, 1));
`else
      s_r = 1'b0;
`endif
      issue(pick(), pick(), 1'($urandom_range(0, 1)), s_r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rdy_mode = 2;
    drain();

    // Single-chunk instance: one RUN cycle.
    in_valid8 = 1'b1;
    a8        = 8'h80;
    b8        = 8'h80;
    #1;
    check("n8_in_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("n8_not_yet_valid", 64'(out_valid8), 64'd0);
    @(negedge clk);
    check("n8_out_valid", 64'(out_valid8), 64'd1);
    check("n8_sum", 64'(sum8), 64'h00);
    check("n8_cout", 64'(cout8), 64'd1);
    check("n8_overflow", 64'(ovf8), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
